// File: rtl/lvds_rx_auto_align.sv
// lvds_rx_auto_align
// Multi-lane receive word aligner. Each lane finds its word boundary on its
// own by sliding a barrel-shift window over {current word, previous word}
// until TRAIN_PATTERN has been seen LOCK_CNT times in a row. Once all lanes
// are locked, the alignment is frozen and aligned words are streamed out.
//
// Ports:
//   sys_clk        system clock, rising edge
//   rst_n          asynchronous active-low reset
//   align_start    single-cycle pulse: start or restart training
//   rx_valid       qualifies rx_data
//   rx_data        raw deserialised words, lane i at [i*W +: W]
//   data_out       aligned words, same packing (meaningful only in DONE)
//   data_out_valid aligned data valid (DONE only), 1 cycle after rx_valid
//   lane_locked    per-lane lock flags
//   slip_pos       per-lane selected shift, lane i at [i*SW +: SW]
//   align_done     all lanes locked, alignment frozen
//   align_fail     training timed out before all lanes locked
module lvds_rx_auto_align #(
  parameter int unsigned   NUM_LANES     = 4,
  parameter int unsigned   W             = 8,
  parameter logic [W-1:0]  TRAIN_PATTERN = 8'hF0,
  parameter int unsigned   LOCK_CNT      = 4,
  parameter int unsigned   TIMEOUT_CYC   = 4096,
  localparam int unsigned  SW            = $clog2(W)
) (
  input  logic                    sys_clk,
  input  logic                    rst_n,
  input  logic                    align_start,
  input  logic                    rx_valid,
  input  logic [NUM_LANES*W-1:0]  rx_data,
  output logic [NUM_LANES*W-1:0]  data_out,
  output logic                    data_out_valid,
  output logic [NUM_LANES-1:0]    lane_locked,
  output logic [NUM_LANES*SW-1:0] slip_pos,
  output logic                    align_done,
  output logic                    align_fail
);

  localparam int unsigned TW       = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [7:0]    LOCK_TGT = 8'(LOCK_CNT);
  localparam logic [SW-1:0] SLIP_MAX = SW'(W - 1);

  typedef enum logic [1:0] {IDLE, TRAIN, DONE, ERROR} state_t;

  state_t                state, state_next;
  logic [W-1:0]          prev      [NUM_LANES];
  logic [SW-1:0]         slip      [NUM_LANES];
  logic [7:0]            match_cnt [NUM_LANES];
  logic [NUM_LANES-1:0]  primed;
  logic [TW-1:0]         tmo;
  logic [NUM_LANES*W-1:0] aligned;
  logic [2*W-1:0]        win;
  logic [2*W-1:0]        shifted;
  logic                  entering;

  // Barrel-shift window per lane and packed slip view.
  always_comb begin
    aligned  = '0;
    slip_pos = '0;
    win      = '0;
    shifted  = '0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      win                 = {rx_data[i*W +: W], prev[i]};
      shifted             = win >> slip[i];
      aligned[i*W +: W]   = shifted[W-1:0];
      slip_pos[i*SW +: SW] = slip[i];
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:        if (align_start) state_next = TRAIN;
      TRAIN: begin
        if (&lane_locked)     state_next = DONE;
        else if (tmo == TMO_LAST) state_next = ERROR;
      end
      DONE, ERROR: if (align_start) state_next = TRAIN;
      default:     state_next = IDLE;
    endcase
  end

  // Accepted start pulse; align_start inside TRAIN never gets here.
  assign entering = (state_next == TRAIN) && (state != TRAIN);

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      tmo   <= '0;
    end else begin
      state <= state_next;
      if (entering)            tmo <= '0;
      else if (state == TRAIN) tmo <= tmo + 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_locked <= '0;
      primed      <= '0;
      for (int unsigned i = 0; i < NUM_LANES; i++) begin
        prev[i]      <= '0;
        slip[i]      <= '0;
        match_cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_LANES; i++) begin
        if (rx_valid) prev[i] <= rx_data[i*W +: W];
        if (entering) begin
          slip[i]        <= '0;
          match_cnt[i]   <= '0;
          lane_locked[i] <= 1'b0;
          primed[i]      <= 1'b0;
        end else if (state == TRAIN && rx_valid) begin
          if (!primed[i]) begin
            primed[i] <= 1'b1;
          end else if (!lane_locked[i]) begin
            if (aligned[i*W +: W] == TRAIN_PATTERN) begin
              match_cnt[i] <= match_cnt[i] + 8'd1;
              if (match_cnt[i] + 8'd1 == LOCK_TGT) lane_locked[i] <= 1'b1;
            end else begin
              match_cnt[i] <= '0;
              slip[i]      <= (slip[i] == SLIP_MAX) ? '0 : slip[i] + 1'b1;
            end
          end
        end
      end
    end
  end

  // Status and data flags follow the next state so they rise on entry to
  // DONE/ERROR and drop on the same edge that accepts a restart.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out       <= '0;
      data_out_valid <= 1'b0;
      align_done     <= 1'b0;
      align_fail     <= 1'b0;
    end else begin
      data_out       <= aligned;
      data_out_valid <= (state_next == DONE) && rx_valid;
      align_done     <= (state_next == DONE);
      align_fail     <= (state_next == ERROR);
    end
  end

endmodule
